// File: rtl/inst_prefetch_queue_pkg.sv
// inst_prefetch_queue_pkg: shared CPU constants and the prefetch queue entry type.
//   INST_SIZE_WORD   - SRAM-like size code for a 4-byte access
//   DEFAULT_RESET_PC - first fetch address after reset
//   q_entry_t        - queued fetch {pc, inst, adel}
package inst_prefetch_queue_pkg;
  localparam logic [1:0] INST_SIZE_WORD = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic adel;
  } q_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry synchronous FIFO with flush, occupancy count and a head taken straight from storage flops.
//   clk, resetn      - clock, asynchronous active-low reset
//   flush            - empty the FIFO (wins over push/pop)
//   push, din        - write an entry
//   pop              - remove the head (only when count != 0)
//   head             - oldest entry, driven from registers only
//   count            - number of valid entries (0..DEPTH)
module prefetch_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  q_entry_t               din,
  input  logic                   pop,
  output q_entry_t               head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  q_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: RESET_PC, inst: 32'h0, adel: 1'b0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rp];
endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher feeding decode from the SRAM-like inst_* port.
//   clk, resetn                  - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc  - flush queue, restart fetch at redirect_pc
//   fetch_valid/pc/inst/adel     - head entry to decode; fetch_ready consumes it
//   inst_req/wr/size/addr/wdata  - request side of the bridge port
//   inst_rdata/addr_ok/data_ok   - bridge handshakes, responses in order
// Optional: INST_PREFETCH_ADEL_EN turns a misaligned redirect into a single
// address-error queue entry and halts fetching until the next redirect.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_adel,
  input  logic        fetch_ready,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic run, pending, pend_stale, halt, adel_pend;
  logic acc, held, pop, push_data, adel_push;
  logic [31:0] req_pc, ret_pc, held_pc;
  logic [CW-1:0] inflight, stale, count;
  logic [CW:0] used;
  q_entry_t head, din;
  // Queue slots plus outstanding requests form the credit pool, so a
  // response always finds a free slot.
  assign used = {1'b0, count} + {1'b0, inflight};
  assign inst_req = pending | (run & ~halt & (used < (CW+1)'(DEPTH)));
  assign inst_wr = 1'b0;
  assign inst_size = INST_SIZE_WORD;
  assign inst_addr = req_pc;
  assign inst_wdata = 32'h0;
  assign acc = inst_req & inst_addr_ok;
  assign held = inst_req & ~inst_addr_ok;
  assign pop = fetch_valid & fetch_ready & ~redirect_valid;
  assign push_data = inst_data_ok & ~redirect_valid & (stale == '0);
  // Nothing is outstanding any more, so ret_pc still holds the redirect target.
  assign adel_push = adel_pend & ~redirect_valid & ~pend_stale & (inflight == '0);
  assign din = '{pc: ret_pc, inst: push_data ? inst_rdata : 32'h0, adel: adel_push};
`ifdef INST_PREFETCH_ADEL_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      halt <= 1'b0;
      adel_pend <= 1'b0;
    end else if (redirect_valid) begin
      halt <= redirect_pc[1:0] != 2'b00;
      adel_pend <= redirect_pc[1:0] != 2'b00;
    end else if (adel_push) begin
      adel_pend <= 1'b0;
    end
  end
`else
  assign halt = 1'b0;
  assign adel_pend = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run <= 1'b0;
      pending <= 1'b0;
      pend_stale <= 1'b0;
      req_pc <= RESET_PC;
      ret_pc <= RESET_PC;
      held_pc <= RESET_PC;
      inflight <= '0;
      stale <= '0;
    end else begin
      run <= 1'b1;
      pending <= held;
      inflight <= inflight + CW'(acc) - CW'(inst_data_ok);
      if (redirect_valid) begin
        // Everything outstanding after this cycle belongs to the old stream;
        // a request still held unaccepted is charged when it is accepted.
        ret_pc <= redirect_pc;
        held_pc <= redirect_pc;
        stale <= inflight + CW'(acc) - CW'(inst_data_ok);
        pend_stale <= held;
        if (!held) req_pc <= redirect_pc;
      end else begin
        if (push_data) ret_pc <= ret_pc + 32'd4;
        stale <= stale - CW'(inst_data_ok & (stale != '0)) + CW'(acc & pend_stale);
        if (acc) begin
          req_pc <= pend_stale ? held_pc : req_pc + 32'd4;
          pend_stale <= 1'b0;
        end
      end
    end
  end
  prefetch_fifo #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .flush(redirect_valid),
    .push(push_data | adel_push),
    .din(din),
    .pop(pop),
    .head(head),
    .count(count)
  );
  assign fetch_valid = count != '0;
  assign fetch_pc = head.pc;
  assign fetch_inst = head.inst;
  assign fetch_adel = head.adel;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: randomized and directed self-checking bench for inst_prefetch_queue.
module tb_inst_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'hbfc00000;
  logic clk = 1'b0, resetn = 1'b0, redirect_valid = 1'b0, fetch_ready = 1'b0;
  logic [31:0] redirect_pc = '0, inst_rdata = '0;
  logic inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic fetch_valid, fetch_adel, inst_req, inst_wr;
  logic [31:0] fetch_pc, fetch_inst, inst_addr, inst_wdata;
  logic [1:0] inst_size;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic adel;
    int cyc;
  } ent_t;
  ent_t got[$];
  logic [31:0] bq[$];
  logic [31:0] acc_log[$];
  int total = 0, bad = 0, aok_pct = 100, dok_pct = 100, cyc = 0;
  bit seq_mode = 0;
  logic [31:0] seq_word = '0;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .fetch_adel(fetch_adel),
    .fetch_ready(fetch_ready), .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a3c96e1;
  endfunction

  // One bridge/decode cycle: choose handshakes, log what the coming edge does.
  task automatic step();
    logic [31:0] a;
    inst_addr_ok = inst_req && ($urandom_range(99) < aok_pct);
    inst_data_ok = (bq.size() > 0) && ($urandom_range(99) < dok_pct);
    inst_rdata = $urandom;
    if (inst_data_ok) begin
      a = bq.pop_front();
      inst_rdata = seq_mode ? seq_word : mem_word(a);
      seq_word = seq_word + 1;
    end
    if (inst_req && inst_addr_ok) begin
      bq.push_back(inst_addr);
      acc_log.push_back(inst_addr);
    end
    if (fetch_valid && fetch_ready && !redirect_valid)
      got.push_back('{pc: fetch_pc, inst: fetch_inst, adel: fetch_adel, cyc: cyc});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    redirect_valid = 1'b0;
    fetch_ready = 1'b0;
    aok_pct = 100;
    dok_pct = 100;
    seq_mode = 0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bq.delete();
    got.delete();
    acc_log.delete();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (inst_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", inst_req); end
    if (inst_addr !== RPC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", inst_addr, RPC); end
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    if (fetch_pc !== RPC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", fetch_pc, RPC); end
    if (fetch_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", fetch_inst); end
    if (fetch_adel !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", fetch_adel); end
    total += 2;
    if (inst_size !== 2'b10 || inst_wr !== 1'b0 || inst_wdata !== 32'h0) begin
      bad++; $display("FAIL const_ports got=%b/%b/%h exp=10/0/0", inst_size, inst_wr, inst_wdata);
    end
    resetn = 1'b1;
    step();
    if (inst_req !== 1'b1) begin bad++; $display("FAIL req_after_reset got=%b exp=1", inst_req); end
  endtask

  task automatic test_stream();
    bit seen = 0;
    do_reset();
    seq_mode = 1;
    seq_word = 32'hA0;
    fetch_ready = 1'b1;
    for (int i = 0; i < 30 && got.size() < 4; i++) begin
      step();
      if (inst_data_ok && !seen) begin
        seen = 1;
        total++;
        if (fetch_valid !== 1'b1) begin bad++; $display("FAIL latency got=%b exp=1", fetch_valid); end
      end
    end
    total++;
    if (got.size() < 4) begin bad++; $display("FAIL stream_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total += 3;
      if (got[i].pc !== RPC + 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, got[i].pc, RPC + 32'(4 * i)); end
      if (got[i].inst !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL stream_inst%0d got=%h exp=%h", i, got[i].inst, 32'hA0 + 32'(i)); end
      if (got[i].cyc !== got[0].cyc + i) begin bad++; $display("FAIL stream_cycle%0d got=%0d exp=%0d", i, got[i].cyc, got[0].cyc + i); end
    end
    seq_mode = 0;
  endtask

  task automatic test_credit();
    logic [31:0] a5;
    do_reset();
    repeat (12) step();
    total += 3;
    if (acc_log.size() !== DEPTH) begin bad++; $display("FAIL credit_accepts got=%0d exp=%0d", acc_log.size(), DEPTH); end
    if (inst_req !== 1'b0) begin bad++; $display("FAIL credit_req got=%b exp=0", inst_req); end
    if (fetch_valid !== 1'b1) begin bad++; $display("FAIL credit_valid got=%b exp=1", fetch_valid); end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    repeat (8) step();
    a5 = acc_log.size() > DEPTH ? acc_log[DEPTH] : 32'hx;
    total += 3;
    if (acc_log.size() !== DEPTH + 1) begin bad++; $display("FAIL credit_refill got=%0d exp=%0d", acc_log.size(), DEPTH + 1); end
    if (a5 !== RPC + 32'd16) begin bad++; $display("FAIL credit_addr got=%h exp=%h", a5, RPC + 32'd16); end
    if (inst_req !== 1'b0) begin bad++; $display("FAIL credit_req2 got=%b exp=0", inst_req); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    dok_pct = 0;
    for (int i = 0; i < 20 && acc_log.size() < 4; i++) step();
    dok_pct = 100;
    step();
    dok_pct = 0;
    redirect_to(32'hbfc00100);
    total++;
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", fetch_valid); end
    dok_pct = 100;
    fetch_ready = 1'b1;
    for (int i = 0; i < 40 && got.size() == 0; i++) step();
    total += 3;
    if (got.size() == 0) begin bad++; $display("FAIL redir_timeout got=0 exp=1 entries"); end
    else begin
      if (got[0].pc !== 32'hbfc00100) begin bad++; $display("FAIL redir_pc got=%h exp=bfc00100", got[0].pc); end
      if (got[0].inst !== mem_word(32'hbfc00100)) begin bad++; $display("FAIL redir_inst got=%h exp=%h", got[0].inst, mem_word(32'hbfc00100)); end
    end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    aok_pct = 0;
    fetch_ready = 1'b1;
    repeat (3) step();
    redirect_to(32'hbfc00100);
    repeat (3) step();
    total += 2;
    if (inst_req !== 1'b1) begin bad++; $display("FAIL pend_req got=%b exp=1", inst_req); end
    if (inst_addr !== RPC) begin bad++; $display("FAIL pend_hold got=%h exp=%h", inst_addr, RPC); end
    aok_pct = 100;
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) step();
    for (int i = 0; i < 40 && got.size() == 0; i++) step();
    total += 3;
    if (acc_log.size() < 2) begin bad++; $display("FAIL pend_accepts got=%0d exp=2", acc_log.size()); end
    else begin
      if (acc_log[0] !== RPC) begin bad++; $display("FAIL pend_addr0 got=%h exp=%h", acc_log[0], RPC); end
      if (acc_log[1] !== 32'hbfc00100) begin bad++; $display("FAIL pend_addr1 got=%h exp=bfc00100", acc_log[1]); end
    end
    total++;
    if (got.size() == 0 || got[0].pc !== 32'hbfc00100) begin
      bad++; $display("FAIL pend_first got=%h exp=bfc00100", got.size() ? got[0].pc : 32'hx);
    end
  endtask

  task automatic test_redirect_dok_pop();
    do_reset();
    dok_pct = 0;
    for (int i = 0; i < 20 && acc_log.size() < 3; i++) step();
    dok_pct = 100;
    repeat (2) step();
    fetch_ready = 1'b1;
    redirect_to(32'hbfc00200);
    total++;
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL dokpop_flush got=%b exp=0", fetch_valid); end
    for (int i = 0; i < 40 && got.size() == 0; i++) step();
    total++;
    if (got.size() == 0 || got[0].pc !== 32'hbfc00200) begin
      bad++; $display("FAIL dokpop_first got=%h exp=bfc00200", got.size() ? got[0].pc : 32'hx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_ready = 1'b1;
    repeat (4) step();
    redirect_to(32'hfffffff8);
    got.delete();
    for (int i = 0; i < 40 && got.size() < 3; i++) step();
    total++;
    if (got.size() < 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i].pc !== 32'hfffffff8 + 32'(4 * i) || got[i].inst !== mem_word(got[i].pc)) begin
        bad++; $display("FAIL wrap_pc%0d got=%h exp=%h", i, got[i].pc, 32'hfffffff8 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, a, rp;
    logic r, rv;
    ent_t e;
    do_reset();
    exp_pc = RPC;
    aok_pct = 70;
    dok_pct = 60;
    for (int n = 0; n < 3000; n++) begin
      fetch_ready = $urandom_range(99) < 70;
      redirect_valid = $urandom_range(99) < 3;
      redirect_pc = $urandom & 32'hfffffffc;
      r = inst_req;
      a = inst_addr;
      rv = redirect_valid;
      rp = redirect_pc;
      step();
      if (r && !inst_addr_ok) begin
        total++;
        if (inst_addr !== a) begin bad++; $display("FAIL rnd_hold got=%h exp=%h", inst_addr, a); end
      end
      total++;
      if (bq.size() > DEPTH) begin bad++; $display("FAIL rnd_outstanding got=%0d exp<=%0d", bq.size(), DEPTH); end
      while (got.size() > 0) begin
        e = got.pop_front();
        total++;
        if (e.pc !== exp_pc || e.inst !== mem_word(exp_pc) || e.adel !== 1'b0) begin
          bad++; $display("FAIL rnd_fetch got=%h/%h/%b exp=%h/%h/0", e.pc, e.inst, e.adel, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (rv) exp_pc = rp;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_ready = 1'b1;
    dok_pct = 50;
    repeat (10) step();
    #3 resetn = 1'b0;
    #1;
    total += 4;
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", fetch_valid); end
    if (inst_req !== 1'b0) begin bad++; $display("FAIL areset_req got=%b exp=0", inst_req); end
    if (inst_addr !== RPC) begin bad++; $display("FAIL areset_addr got=%h exp=%h", inst_addr, RPC); end
    if (fetch_pc !== RPC || fetch_inst !== 32'h0) begin bad++; $display("FAIL areset_head got=%h/%h exp=%h/0", fetch_pc, fetch_inst, RPC); end
    @(posedge clk);
    #1;
    do_reset();
  endtask

`ifdef INST_PREFETCH_ADEL_EN
  task automatic test_adel();
    int n;
    do_reset();
    fetch_ready = 1'b1;
    repeat (5) step();
    redirect_to(32'hbfc00102);
    got.delete();
    n = acc_log.size();
    repeat (20) step();
    total += 3;
    if (acc_log.size() !== n) begin bad++; $display("FAIL adel_noreq got=%0d exp=%0d", acc_log.size(), n); end
    if (inst_req !== 1'b0) begin bad++; $display("FAIL adel_req got=%b exp=0", inst_req); end
    if (got.size() !== 1) begin bad++; $display("FAIL adel_count got=%0d exp=1", got.size()); end
    else begin
      total++;
      if (got[0].pc !== 32'hbfc00102 || got[0].inst !== 32'h0 || got[0].adel !== 1'b1) begin
        bad++; $display("FAIL adel_entry got=%h/%h/%b exp=bfc00102/0/1", got[0].pc, got[0].inst, got[0].adel);
      end
    end
    redirect_to(32'hbfc00300);
    got.delete();
    for (int i = 0; i < 20 && got.size() == 0; i++) step();
    total++;
    if (got.size() == 0 || got[0].pc !== 32'hbfc00300 || got[0].adel !== 1'b0) begin
      bad++; $display("FAIL adel_resume got=%h exp=bfc00300", got.size() ? got[0].pc : 32'hx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_redirect_inflight();
    test_redirect_pending();
    test_redirect_dok_pop();
    test_wrap();
    test_random();
    test_async_reset();
`ifdef INST_PREFETCH_ADEL_EN
    test_adel();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
